// File: rtl/ifid_imm_split.sv
// IF/ID stage: registered output slot plus a one-entry skid buffer, with opcode decode
// and raw immediate slicing for the downstream immediate extender.
module ifid_imm_split #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_inst,
    output logic [XLEN-1:0] out_pc,
    output logic [11:0]     immTypeI,
    output logic [11:0]     immTypeS,
    output logic [12:0]     immTypeB,
    output logic [19:0]     immTypeU,
    output logic [19:0]     immTypeJ,
    output logic [2:0]      extOp,
    output logic            illegal
);

    localparam logic [2:0] ExtI    = 3'b000;
    localparam logic [2:0] ExtS    = 3'b001;
    localparam logic [2:0] ExtB    = 3'b010;
    localparam logic [2:0] ExtJ    = 3'b011;
    localparam logic [2:0] ExtU    = 3'b100;
    localparam logic [2:0] ExtNone = 3'b111;

    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc;
        logic [11:0]     immI;
        logic [11:0]     immS;
        logic [12:0]     immB;
        logic [19:0]     immU;
        logic [19:0]     immJ;
        logic [2:0]      extOp;
        logic            illegal;
    } entry_t;

    entry_t inDec;
    entry_t outEntry, outEntryD;
    entry_t skidEntry, skidEntryD;
    logic   outValid, outValidD;
    logic   skidValid, skidValidD;
    logic   inReadyQ;
    logic   inFire;
    logic   outFree;

    // Input-side decode; the whole entry is captured into whichever register loads it.
    always_comb begin
        inDec.inst    = in_inst;
        inDec.pc      = in_pc;
        inDec.immI    = in_inst[31:20];
        inDec.immS    = {in_inst[31:25], in_inst[11:7]};
        inDec.immB    = {in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
        inDec.immU    = in_inst[31:12];
        inDec.immJ    = {in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21]};
        inDec.extOp   = ExtNone;
        inDec.illegal = 1'b0;
        case (in_inst[6:0])
            7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011: inDec.extOp = ExtI;
            7'b0100011:                                     inDec.extOp = ExtS;
            7'b1100011:                                     inDec.extOp = ExtB;
            7'b0110111, 7'b0010111:                         inDec.extOp = ExtU;
            7'b1101111:                                     inDec.extOp = ExtJ;
            7'b0110011, 7'b0001111:                         inDec.extOp = ExtNone;
            default:                                        inDec.illegal = 1'b1;
        endcase
    end

    assign inFire  = in_valid & inReadyQ;
    assign outFree = !outValid | out_ready;

    always_comb begin
        outValidD  = outValid;
        skidValidD = skidValid;
        outEntryD  = outEntry;
        skidEntryD = skidEntry;
        if (outFree) begin
            if (skidValid) begin
                outEntryD = skidEntry;
                outValidD = 1'b1;
                if (inFire) begin
                    skidEntryD = inDec;
                end else begin
                    skidValidD = 1'b0;
                end
            end else if (inFire) begin
                outEntryD = inDec;
                outValidD = 1'b1;
            end else begin
                outValidD = 1'b0;
            end
        end else if (inFire) begin
            skidEntryD = inDec;
            skidValidD = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            outValid  <= 1'b0;
            skidValid <= 1'b0;
            inReadyQ  <= 1'b1;
            outEntry  <= '{inst: '0, pc: '0, immI: '0, immS: '0, immB: '0, immU: '0,
                           immJ: '0, extOp: ExtNone, illegal: 1'b0};
            skidEntry <= '0;
        end else if (flush) begin
            // Drop everything buffered but leave the visible data fields untouched.
            outValid  <= 1'b0;
            skidValid <= 1'b0;
            inReadyQ  <= 1'b1;
        end else begin
            outValid  <= outValidD;
            skidValid <= skidValidD;
            inReadyQ  <= !skidValidD;
            outEntry  <= outEntryD;
            skidEntry <= skidEntryD;
        end
    end

    assign in_ready  = inReadyQ;
    assign out_valid = outValid;
    assign out_inst  = outEntry.inst;
    assign out_pc    = outEntry.pc;
    assign immTypeI  = outEntry.immI;
    assign immTypeS  = outEntry.immS;
    assign immTypeB  = outEntry.immB;
    assign immTypeU  = outEntry.immU;
    assign immTypeJ  = outEntry.immJ;
    assign extOp     = outEntry.extOp;
    assign illegal   = outEntry.illegal;

endmodule

// File: tb/tb_ifid_imm_split.sv
// Bench for ifid_imm_split: directed scenarios with literal expectations plus a random phase,
// all cross-checked every cycle against a two-deep FIFO model of the stage.
module tb_ifid_imm_split;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, in_ready, out_valid, out_ready, illegal;
    logic [31:0] in_inst, in_pc, out_inst, out_pc;
    logic [11:0] immTypeI, immTypeS;
    logic [12:0] immTypeB;
    logic [19:0] immTypeU, immTypeJ;
    logic [2:0]  extOp;

    int nPass = 0;
    int nTotal = 0;

    always #5 clk = ~clk;

    ifid_imm_split #(.XLEN(32)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
        .immTypeI(immTypeI), .immTypeS(immTypeS), .immTypeB(immTypeB),
        .immTypeU(immTypeU), .immTypeJ(immTypeJ), .extOp(extOp), .illegal(illegal)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nTotal++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else nPass++;
    endtask

    // {illegal, extOp} from the opcode table
    function automatic logic [3:0] decodeOp(input logic [6:0] op);
        case (op)
            7'h03, 7'h13, 7'h67, 7'h73: return 4'b0000;
            7'h23:                      return 4'b0001;
            7'h63:                      return 4'b0010;
            7'h37, 7'h17:               return 4'b0100;
            7'h6F:                      return 4'b0011;
            7'h33, 7'h0F:               return 4'b0111;
            default:                    return 4'b1111;
        endcase
    endfunction

    // Model: the stage holds up to two instructions in arrival order; the head is the output.
    logic [63:0] mq[$];
    logic [31:0] lastInst, lastPc;
    bit          lastIsReset;
    bit          checkEn = 0;

    always @(posedge clk) begin
        int sz;
        if (reset) begin
            mq.delete();
            lastInst    = 0;
            lastPc      = 0;
            lastIsReset = 1;
            checkEn     = 1;
        end else if (checkEn) begin
            if (flush) begin
                mq.delete();
            end else begin
                sz = mq.size();
                if (sz > 0 && out_ready) void'(mq.pop_front());
                if (in_valid && sz < 2) mq.push_back({in_inst, in_pc});
                if (mq.size() > 0) begin
                    lastInst    = mq[0][63:32];
                    lastPc      = mq[0][31:0];
                    lastIsReset = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [31:0] i;
        logic [3:0]  d;
        if (checkEn) begin
            i = lastInst;
            d = lastIsReset ? 4'b0111 : decodeOp(i[6:0]);
            check("in_ready", 64'(in_ready), 64'(mq.size() < 2));
            check("out_valid", 64'(out_valid), 64'(mq.size() > 0));
            check("out_inst", 64'(out_inst), 64'(i));
            check("out_pc", 64'(out_pc), 64'(lastPc));
            check("immTypeI", 64'(immTypeI), 64'(i[31:20]));
            check("immTypeS", 64'(immTypeS), 64'({i[31:25], i[11:7]}));
            check("immTypeB", 64'(immTypeB), 64'({i[31], i[7], i[30:25], i[11:8], 1'b0}));
            check("immTypeU", 64'(immTypeU), 64'(i[31:12]));
            check("immTypeJ", 64'(immTypeJ), 64'({i[31], i[19:12], i[20], i[30:21]}));
            check("extOp", 64'(extOp), 64'(d[2:0]));
            check("illegal", 64'(illegal), 64'(d[3]));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc);
        in_valid = v;
        in_inst  = inst;
        in_pc    = pc;
    endtask

    initial begin
        logic [31:0] streamInst[4];
        logic [19:0] streamImm[4];
        logic [6:0]  ops[11];
        logic [31:0] r;
        ops = '{7'h03, 7'h13, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h0F};

        // Reset with fetch already presenting an instruction
        reset = 1; flush = 0; out_ready = 1;
        drive(1, 32'h00100093, 32'h0000_0040);
        tick(); tick();
        check("rst out_valid", 64'(out_valid), 64'd0);
        check("rst in_ready", 64'(in_ready), 64'd1);
        check("rst extOp", 64'(extOp), 64'd7);
        check("rst out_inst", 64'(out_inst), 64'd0);
        check("rst immTypeU", 64'(immTypeU), 64'd0);
        reset = 0;
        drive(0, 0, 0);
        tick();

        // Single addi
        drive(1, 32'h00100093, 32'h0000_0100);
        tick();
        drive(0, 0, 0);
        check("addi out_valid", 64'(out_valid), 64'd1);
        check("addi immTypeI", 64'(immTypeI), 64'h001);
        check("addi extOp", 64'(extOp), 64'd0);
        check("addi illegal", 64'(illegal), 64'd0);
        check("addi out_pc", 64'(out_pc), 64'h100);
        tick();

        // Back-to-back stream
        streamInst = '{32'hF1F2F0B7, 32'h0020A223, 32'h0080006F, 32'h00000000};
        streamImm  = '{20'hF1F2F, 20'h00004, 20'h00004, 20'h0};
        for (int k = 0; k < 4; k++) begin
            drive(1, streamInst[k], 32'h200 + 32'(4 * k));
            tick();
            check("stream out_valid", 64'(out_valid), 64'd1);
            check("stream out_inst", 64'(out_inst), 64'(streamInst[k]));
            case (k)
                0: begin
                    check("lui immTypeU", 64'(immTypeU), 64'(streamImm[k]));
                    check("lui extOp", 64'(extOp), 64'd4);
                end
                1: begin
                    check("sw immTypeS", 64'(immTypeS), 64'(streamImm[k]));
                    check("sw extOp", 64'(extOp), 64'd1);
                end
                2: begin
                    check("jal immTypeJ", 64'(immTypeJ), 64'(streamImm[k]));
                    check("jal extOp", 64'(extOp), 64'd3);
                end
                default: begin
                    check("zero illegal", 64'(illegal), 64'd1);
                    check("zero extOp", 64'(extOp), 64'd7);
                end
            endcase
        end
        drive(0, 0, 0);
        tick();

        // Stall: A to output, B to skid, C held by fetch
        out_ready = 0;
        drive(1, 32'h00A00113, 32'h300); tick();
        drive(1, 32'h00B00193, 32'h304); tick();
        check("stall in_ready", 64'(in_ready), 64'd0);
        drive(1, 32'h00C00213, 32'h308); tick(); tick();
        check("stall head A", 64'(out_inst), 64'h00A00113);
        out_ready = 1;
        tick();
        check("drain B", 64'(out_inst), 64'h00B00193);
        check("drain in_ready", 64'(in_ready), 64'd1);
        tick();
        drive(0, 0, 0);
        check("drain C", 64'(out_inst), 64'h00C00213);
        check("drain C pc", 64'(out_pc), 64'h308);
        tick();
        check("drained", 64'(out_valid), 64'd0);

        // Flush with both registers full and fetch presenting a third
        out_ready = 0;
        drive(1, 32'h01100293, 32'h400); tick();
        drive(1, 32'h01200313, 32'h404); tick();
        flush = 1;
        drive(1, 32'h01300393, 32'h408); tick();
        flush = 0;
        drive(0, 0, 0);
        check("flush out_valid", 64'(out_valid), 64'd0);
        check("flush in_ready", 64'(in_ready), 64'd1);
        out_ready = 1;
        // Instruction accepted during a flush cycle is discarded too
        flush = 1;
        drive(1, 32'h01400413, 32'h40C); tick();
        flush = 0;
        drive(0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("post-flush idle", 64'(out_valid), 64'd0);
        end

        // Held output stays stable, then exactly one transfer
        out_ready = 0;
        drive(1, 32'hFE5FF0E3, 32'h500); tick();
        drive(0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            check("hold out_valid", 64'(out_valid), 64'd1);
            check("hold out_inst", 64'(out_inst), 64'hFE5FF0E3);
            check("hold immTypeB", 64'(immTypeB), 64'h1FE0);
            check("hold extOp", 64'(extOp), 64'd2);
            tick();
        end
        out_ready = 1;
        tick();
        check("single transfer", 64'(out_valid), 64'd0);

        // Random traffic; the per-cycle model compare does the checking
        for (int n = 0; n < 3000; n++) begin
            r = $urandom;
            if ($urandom_range(0, 3) != 0) r[6:0] = ops[$urandom_range(0, 10)];
            drive(1'($urandom_range(0, 3) != 0), r, $urandom);
            out_ready = 1'($urandom_range(0, 2) != 0);
            flush     = 1'($urandom_range(0, 40) == 0);
            reset     = 1'($urandom_range(0, 300) == 0);
            tick();
        end
        reset = 0; flush = 0;
        drive(0, 0, 0);
        tick(); tick();

        $display("%0d/%0d checks passed", nPass, nTotal);
        $finish;
    end

endmodule

// File: doc/ifid_imm_split.md
Name: ifid_imm_split

Overview:
IF/ID pipeline stage that sits directly upstream of the immediate extender `ext`. It accepts fetched instructions over a valid/ready handshake and buffers them in an output register plus a one-entry skid register. It decodes the opcode into `extOp` and slices the raw immediate fields into the `immTypeI/S/B/U/J` buses that `ext` consumes. All outputs are registered.

Parameters:
XLEN, 32, width of instruction and PC buses (fixed at 32 for RV32I).

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
flush  input  1  synchronous kill of all buffered instructions (branch/jump redirect)
in_valid  input  1  fetch presents an instruction
in_ready  output  1  stage can accept; registered, equals !skid_valid
in_inst  input  32  instruction word
in_pc  input  32  instruction address
out_valid  output  1  decoded instruction available
out_ready  input  1  downstream accepts
out_inst  output  32  registered instruction
out_pc  output  32  registered PC
immTypeI  output  12  inst[31:20]
immTypeS  output  12  {inst[31:25],inst[11:7]}
immTypeB  output  13  {inst[31],inst[7],inst[30:25],inst[11:8],1'b0}
immTypeU  output  20  inst[31:12]
immTypeJ  output  20  {inst[31],inst[19:12],inst[20],inst[30:21]} (imm[20:1])
extOp  output  3  000 I, 001 S, 010 B, 011 J, 100 U, 111 none
illegal  output  1  opcode not in the RV32I base set

Behaviour:
- Clock and reset: single clock `clk`. Reset is synchronous and active-high on `reset`.
- Reset values (next edge with reset=1): out_valid=0, skid_valid=0, in_ready=1, out_inst=0, out_pc=0, all imm buses=0, extOp=111, illegal=0.
- Decode is combinational on the input side. Decoded fields, inst and pc are captured together into whichever register (skid or output) loads them.
- Opcode map:
  - 0000011, 0010011, 1100111, 1110011 → I
  - 0100011 → S
  - 1100011 → B
  - 0110111, 0010111 → U
  - 1101111 → J
  - 0110011, 0001111 → 111, not illegal
  - any other opcode → 111, illegal=1
- All five imm buses are always driven from the instruction, independent of extOp.
- Handshake:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - Output register "free" = !out_valid | out_ready.
- Register update per edge (priority: reset > flush > normal):
  - If free and skid_valid: output loads the skid entry. If in_fire in the same cycle, the new instruction loads into skid (skid stays valid). Otherwise skid_valid clears.
  - If free, !skid_valid and in_fire: output loads the input, out_valid=1.
  - If free with no source: out_valid=0. Data outputs hold their last values.
  - If not free and in_fire: the input loads into skid, skid_valid=1.
- Latency: 1 cycle from in_fire to out_valid when there is no stall. Throughput is 1 instruction per cycle.
- Ordering: strict FIFO. The skid entry always leaves before any newer instruction.
- in_ready is registered: it drops the cycle after the skid fills and rises the cycle after the skid drains. in_ready never depends combinationally on out_ready.
- flush:
  - Next edge: out_valid=0, skid_valid=0, in_ready=1.
  - An instruction accepted in the flush cycle is discarded.
  - Data outputs hold their last values.
  - flush together with reset: reset values apply.
- Reset mid-stall: all buffered instructions are dropped. No output fires in the reset cycle.
- While out_valid=1 and out_ready=0, all out_* and decode outputs are stable.

Test Plan:
1. Assert reset 2 cycles with in_valid=1 → out_valid=0, in_ready=1, extOp=111, all data outputs=0; no transfer occurs.
2. Send addi 0x00100093 with out_ready=1 → next cycle out_valid=1, immTypeI=0x001, extOp=000, illegal=0, out_pc matches.
3. Send a stream of 4 back-to-back instructions with out_ready=1:
   - lui 0xF1F2F0B7 → immTypeU=0xF1F2F, extOp=100
   - sw 0x0020A223 → immTypeS=0x004, extOp=001
   - jal 0x0080006F → immTypeJ=0x00004, extOp=011
   - word 0x00000000 → illegal=1, extOp=111
   Required: one output per cycle, in order.
4. Hold out_ready=0 and send 3 instructions → first in output, second in skid, in_ready=0 the next cycle, third held by fetch. Raise out_ready → outputs appear in order A, B, C; in_ready returns to 1.
5. With output and skid both full, pulse flush with in_valid=1 → next cycle out_valid=0, in_ready=1; none of the three instructions ever appears at the output.
6. Hold out_valid=1 with out_ready=0 for 5 cycles → all outputs stable; then out_ready=1 → exactly one transfer.
